// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - two-requester round-robin front end for a shared 32-bit shift unit
//
// Ports:
//   clock, reset_n            rising-edge clock, asynchronous active-low reset
//   req0_valid/ready          requester 0 handshake
//   req0_data/shamt/op        operand A, shift amount, opcode (00 sll, 01 srl, 10 sra, 11 pass)
//   req1_*                    same as requester 0, for requester 1
//   rsp_valid/ready           single-entry response buffer handshake
//   rsp_id, rsp_data          owning requester ID and registered shift result

module shift_arbiter (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_data,
    input  logic [4:0]  req0_shamt,
    input  logic [1:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_data,
    input  logic [4:0]  req1_shamt,
    input  logic [1:0]  req1_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_data
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    function automatic logic [31:0] shift_unit(
        input logic [31:0] a,
        input logic [4:0]  s,
        input logic [1:0]  op
    );
        logic [31:0] r;
        case (op)
            OP_SLL:  r = a << s;
            OP_SRL:  r = a >> s;
            OP_SRA:  r = $unsigned($signed(a) >>> s);
            default: r = a;
        endcase
        return r;
    endfunction

    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_id_q, rsp_id_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        last_grant_q, last_grant_d;

    logic        slot_free;
    logic        grant_any;
    logic        grant_id;
    logic        accept;
    logic [31:0] sel_data;
    logic [4:0]  sel_shamt;
    logic [1:0]  sel_op;

    // The buffer can take a new result when empty or when it is being drained
    // in the same cycle, which gives back-to-back throughput.
    assign slot_free = !rsp_valid_q || rsp_ready;

    // On a tie the requester that did not win last time is chosen; with a
    // single valid that requester wins regardless of history.
    assign grant_any = req0_valid || req1_valid;
    assign grant_id  = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;

    // reset_n gates the readies so nothing is offered while reset is held,
    // even though the empty buffer would otherwise look free.
    assign req0_ready = reset_n && slot_free && grant_any && !grant_id;
    assign req1_ready = reset_n && slot_free && grant_any &&  grant_id;
    assign accept     = req0_ready || req1_ready;

    assign sel_data  = grant_id ? req1_data  : req0_data;
    assign sel_shamt = grant_id ? req1_shamt : req0_shamt;
    assign sel_op    = grant_id ? req1_op    : req0_op;

    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            rsp_valid_d  = 1'b1;
            rsp_id_d     = grant_id;
            rsp_data_d   = shift_unit(sel_data, sel_shamt, sel_op);
            last_grant_d = grant_id;
        end else if (rsp_ready) begin
            // Payload and ID are left untouched after a drain.
            rsp_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= 32'd0;
            // Starting at 1 lets requester 0 win the first tie.
            last_grant_q <= 1'b1;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Shares one 32-bit shift unit between two requesters, typically the ALU execute path and the multiply/divide sequencer. Each requester presents an operand, a 5-bit shift amount and an opcode over a valid/ready handshake. A round-robin arbiter grants the unit to one requester per cycle. The result is registered into a single-entry response buffer, tagged with the requester ID, and drained over a valid/ready handshake.

## Interface
- Parameters: none; data width is fixed at 32 bits and the shift amount at 5 bits.
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has an operation pending
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_data  in  32  operand A, requester 0
- req0_shamt  in  5  shift amount, requester 0
- req0_op  in  2  00 sll, 01 srl, 10 sra, 11 pass-through (result = A)
- req1_valid, req1_ready, req1_data, req1_shamt, req1_op  same as requester 0, for requester 1
- rsp_valid  out  1  response buffer holds a result
- rsp_ready  in  1  consumer takes the result this cycle
- rsp_id  out  1  ID of the requester that owns rsp_data
- rsp_data  out  32  shift result

## Operation
- Accept condition:
  - `slot_free = !rsp_valid || rsp_ready`.
  - A request is accepted when its valid and ready are both high at a rising edge.
- Arbitration (combinational, from the valid inputs and `last_grant`):
  - Only one valid: grant it.
  - Both valid: grant the requester that is not `last_grant`.
  - `reqN_ready = grantN && slot_free`. At most one ready is high per cycle.
  - A ready may depend combinationally on the valids. No valid depends on a ready.
- On accept:
  - `last_grant` ← granted ID.
  - `rsp_data` ← shift(A, shamt, op) of the granted requester.
  - `rsp_id` ← granted ID.
  - `rsp_valid` ← 1.
- On `rsp_ready && rsp_valid` with no accept in the same cycle: `rsp_valid` ← 0. `rsp_data` and `rsp_id` hold their values.
- Drain and accept in the same cycle: the buffer is overwritten with the new result and `rsp_valid` stays 1, giving full throughput.
- `last_grant` changes only on an accept. An idle or stalled cycle never rotates priority.
- Shift semantics:
  - sll: zeros fill from the LSB.
  - srl: zeros fill from the MSB.
  - sra: bit 31 is replicated.
  - shamt 0 returns A unchanged for every op.
  - shamt is taken modulo 32 by its width, so no amount above 31 exists.
- Requesters must hold their valid and payload stable until accepted. The block does not sample a payload while the corresponding ready is low.
- Reset (`reset_n` low, asynchronous):
  - `rsp_valid` = 0, `rsp_data` = 0, `rsp_id` = 0, `last_grant` = 1, so requester 0 wins the first tie.
  - A result in the buffer is discarded, and no response for it is ever produced.
  - While in reset, both readies are 0.
- Reset release: synchronous in effect. The first accept is possible at the first rising edge on which `reset_n` is sampled high.

## Timing
- Latency: accept at edge k → `rsp_valid` = 1 with the result visible after edge k, i.e. one cycle.
- Throughput: one operation per cycle while `rsp_ready` is held high.
- Backpressure:
  - With `rsp_valid` = 1 and `rsp_ready` = 0, both readies are 0.
  - The buffer and `rsp_id` hold their values for as long as the stall lasts.
- Combinational paths:
  - reqN_valid → reqM_ready.
  - rsp_ready → reqN_ready.
  - The payload path is register-bounded: it runs through the operand mux and the shift unit into `rsp_data`.

## Test plan
- Reset, then single op:
  - Stimulus: req0 sll, A = 0x0000_0001, shamt = 4, rsp_ready = 1.
  - Required: req0_ready = 1 that cycle; next cycle rsp_valid = 1, rsp_id = 0, rsp_data = 0x0000_0010.
- Op coverage on requester 1:
  - Stimulus: A = 0x8000_00F0, shamt = 4.
  - Required: srl → 0x0800_000F; sra → 0xF800_000F; pass-through → 0x8000_00F0.
  - Required: shamt = 0 with any op → 0x8000_00F0; sll with shamt = 31 and A = 1 → 0x8000_0000.
- Round-robin fairness:
  - Stimulus: both valid continuously for 6 cycles, rsp_ready = 1.
  - Required: grants alternate 0,1,0,1,0,1 starting with 0 after reset; rsp_id follows one cycle later.
- Backpressure:
  - Stimulus: fill the buffer, then hold rsp_ready = 0 for 3 cycles with both requesters valid.
  - Required: both readies stay 0; rsp_data and rsp_id are stable.
  - Required: raising rsp_ready drains the held result and accepts the next requester in the same cycle.
- Priority not rotated by stalls:
  - Stimulus: last_grant = 0, then 2 stall cycles, then both requesters valid.
  - Required: requester 1 is granted.
- Mid-operation reset:
  - Stimulus: assert reset_n = 0 asynchronously (between edges) while rsp_valid = 1.
  - Required: rsp_valid drops immediately, rsp_data = 0, readies = 0.
  - Required: after release with both requesters valid, requester 0 is granted first.
